conv_image_ram: RTL and testbench

- Single-port synchronous 64x8 image memory holding one 8x8 pixel frame, row-major (address = line*8 + column).
- Feeds the 3x3 convolution engine, which streams addresses 0..63 and captures pixels into its local buffer.
- Reset re-establishes a known default frame so the convolver can run without a prior write phase.

---
 rtl/conv_pkg.sv | 24 ++
 rtl/conv_image_ram.sv | 70 +++++++
 tb/tb_conv_image_ram.sv | 132 +++++++++++++
 3 files changed

// File: rtl/conv_pkg.sv
// ----------------------------------------------------------------------------
// conv_pkg
// Shared constants and types for the 8x8 image path: the frame RAM and the
// 3x3 convolution engine (and its bench) agree on geometry through here.
//   IMG_W, IMG_H   frame width/height in pixels
//   PIX_W          pixel width in bits
//   ADDR_W         row-major pixel index width (line*IMG_W + column)
//   default_pixel  content of a word after reset: its own index, zero-extended
// ----------------------------------------------------------------------------
package conv_pkg;

    localparam int IMG_W  = 8;
    localparam int IMG_H  = 8;
    localparam int PIX_W  = 8;
    localparam int ADDR_W = 6;

    typedef logic [PIX_W-1:0]  pixel_t;
    typedef logic [ADDR_W-1:0] pix_addr_t;

    function automatic pixel_t default_pixel(input pix_addr_t addr);
        return pixel_t'(addr);
    endfunction

endpackage

// File: rtl/conv_image_ram.sv
// ----------------------------------------------------------------------------
// conv_image_ram
// Single-port synchronous 64x8 frame memory (one 8x8 frame, row-major).
// Asynchronous reset reloads the default frame mem[i] = i so the convolver can
// run without a prior write phase.
//
// Ports:
//   clk      rising-edge clock
//   rst      asynchronous active-high reset
//   wr       write enable, writes din at address on the clock edge
//   address  row-major pixel index
//   din      write data
//   dout     registered read data, one-cycle latency, updated every edge
//
// Build option:
//   CONV_RAM_WRITE_FIRST_EN  defined   -> read-during-write returns din
//                            undefined -> read-during-write returns old word
// ----------------------------------------------------------------------------
module conv_image_ram
    import conv_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 6,
    parameter int DEPTH  = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout
);

    generate
        if (DEPTH != 2**ADDR_W) begin : g_bad_depth
            $error("conv_image_ram: DEPTH must equal 2**ADDR_W");
        end
    endgenerate

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_dout;

    // Memory lives in flops because the reset must restore every word
    // asynchronously; a macro RAM could not honour that.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= DATA_W'(default_pixel(conv_pkg::pix_addr_t'(i)));
            end
        end else if (wr) begin
            r_mem[address] <= din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dout <= '0;
        end else begin
`ifdef CONV_RAM_WRITE_FIRST_EN
            r_dout <= wr ? din : r_mem[address];
`else
            // Read-first: the array still holds the pre-write word on this edge.
            r_dout <= r_mem[address];
`endif
        end
    end

    assign dout = r_dout;

endmodule

// File: tb/tb_conv_image_ram.sv
module tb_conv_image_ram;

    logic       clk;
    logic       rst;
    logic       wr;
    logic [5:0] address;
    logic [7:0] din;
    logic [7:0] dout;

    int n_chk = 0;
    int n_err = 0;

    conv_image_ram #(
        .DATA_W (8),
        .ADDR_W (6),
        .DEPTH  (64)
    ) u_dut (
        .clk     (clk),
        .rst     (rst),
        .wr      (wr),
        .address (address),
        .din     (din),
        .dout    (dout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %02h expected %02h", tag, got, exp);
        end
    endtask

    // Drive inputs mid-cycle, then sample just after the active edge.
    task automatic access(input logic w, input logic [5:0] a, input logic [7:0] d);
        @(negedge clk);
        wr      = w;
        address = a;
        din     = d;
        @(posedge clk);
        #1;
    endtask

    logic [5:0] a_wrap;
    logic [7:0] exp_rdw;

    initial begin
        rst     = 1'b0;
        wr      = 1'b0;
        address = '0;
        din     = '0;

        // Reset before any clock edge
        #1 rst = 1'b1;
        #1 check("reset_dout", dout, 8'h00);

        @(negedge clk);
        rst = 1'b0;

        // Default frame
        for (int i = 0; i < 64; i++) begin
            access(1'b0, 6'(i), 8'h00);
            check($sformatf("default[%0d]", i), dout, 8'(i));
        end

        // Write / readback
        access(1'b1, 6'd10, 8'hA5);
        access(1'b1, 6'd63, 8'h3C);
        access(1'b1, 6'd0,  8'hFF);
        wr = 1'b0;
        access(1'b0, 6'd10, 8'h00); check("rd_10", dout, 8'hA5);
        access(1'b0, 6'd63, 8'h00); check("rd_63", dout, 8'h3C);
        access(1'b0, 6'd0,  8'h00); check("rd_0",  dout, 8'hFF);
        access(1'b0, 6'd9,  8'h00); check("nb_9",  dout, 8'd9);
        access(1'b0, 6'd11, 8'h00); check("nb_11", dout, 8'd11);

        // Latency: dout must hold between edges and lag the address by one cycle
        access(1'b0, 6'd5, 8'h00); check("lat_5", dout, 8'd5);
        @(negedge clk); address = 6'd6;
        #2 check("lat_hold_5", dout, 8'd5);
        @(posedge clk); #1 check("lat_6", dout, 8'd6);
        @(negedge clk); address = 6'd7;
        #2 check("lat_hold_6", dout, 8'd6);
        @(posedge clk); #1 check("lat_7", dout, 8'd7);

        // Read-during-write
`ifdef CONV_RAM_WRITE_FIRST_EN
        exp_rdw = 8'h77;
`else
        exp_rdw = 8'd20;
`endif
        access(1'b0, 6'd20, 8'h00); check("rdw_pre",  dout, 8'd20);
        access(1'b1, 6'd20, 8'h77); check("rdw_same", dout, exp_rdw);
        access(1'b0, 6'd20, 8'h00); check("rdw_next", dout, 8'h77);

        // Asynchronous reset mid-operation
        access(1'b1, 6'd3, 8'h55);
        access(1'b0, 6'd3, 8'h00); check("pre_rst_3", dout, 8'h55);
        @(negedge clk);
        #2 rst = 1'b1;
        #1 check("async_rst_dout", dout, 8'h00);
        wr = 1'b1; address = 6'd3; din = 8'hAA;
        @(posedge clk); #1 check("rst_hold_dout", dout, 8'h00);
        @(negedge clk);
        rst = 1'b0;
        wr  = 1'b0;
        access(1'b0, 6'd3,  8'h00); check("post_rst_3",  dout, 8'd3);
        access(1'b0, 6'd10, 8'h00); check("post_rst_10", dout, 8'd10);
        access(1'b0, 6'd20, 8'h00); check("post_rst_20", dout, 8'd20);

        // Full sweep with an address counter that wraps 63 -> 0
        a_wrap = '0;
        for (int i = 0; i < 64; i++) begin
            access(1'b1, a_wrap, 8'(255 - i));
            a_wrap = a_wrap + 6'd1;
        end
        for (int i = 0; i < 65; i++) begin
            access(1'b0, a_wrap, 8'h00);
            check($sformatf("sweep[%0d]", a_wrap), dout, 8'(255 - int'(a_wrap)));
            a_wrap = a_wrap + 6'd1;
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
